// File: rtl/parallel_to_serial.sv
// 64-bit word serializer: accepts eight byte lanes over valid/ready and shifts
// them out one bit per BIT_DIV clocks with a frame strobe and an end-of-frame pulse.
module parallel_to_serial #(
    parameter int BIT_DIV   = 1,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] D0,
    input  logic [7:0] D1,
    input  logic [7:0] D2,
    input  logic [7:0] D3,
    input  logic [7:0] D4,
    input  logic [7:0] D5,
    input  logic [7:0] D6,
    input  logic [7:0] D7,
    input  logic       in_valid,
    output logic       in_ready,
    output logic       sdata,
    output logic       sframe,
    output logic       done
);

    localparam int DIV_W = (BIT_DIV > 1) ? $clog2(BIT_DIV) : 1;
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(BIT_DIV - 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t      state_q, state_d;
    logic [63:0] shift_q, shift_d;
    logic [5:0]  bitcnt_q, bitcnt_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic        sdata_q, sdata_d;
    logic        sframe_q, sframe_d;
    logic        done_q, done_d;
    logic        in_ready_q, in_ready_d;

    logic [63:0] word;
    logic [5:0]  next_cnt;

    assign word = {D7, D6, D5, D4, D3, D2, D1, D0};

    // Frame position to word bit index; 63 - c is the bitwise inverse for 6 bits.
    function automatic logic [5:0] bit_idx(input logic [5:0] c);
        return MSB_FIRST ? ~c : c;
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= IDLE;
            shift_q    <= '0;
            bitcnt_q   <= '0;
            div_q      <= '0;
            sdata_q    <= 1'b0;
            sframe_q   <= 1'b0;
            done_q     <= 1'b0;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            shift_q    <= shift_d;
            bitcnt_q   <= bitcnt_d;
            div_q      <= div_d;
            sdata_q    <= sdata_d;
            sframe_q   <= sframe_d;
            done_q     <= done_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        shift_d    = shift_q;
        bitcnt_d   = bitcnt_q;
        div_d      = div_q;
        sdata_d    = 1'b0;
        sframe_d   = 1'b0;
        done_d     = 1'b0;
        in_ready_d = 1'b0;
        next_cnt   = bitcnt_q + 6'd1;

        case (state_q)
            IDLE: begin
                in_ready_d = 1'b1;
                // in_ready_q gates acceptance so the first edge after reset only raises ready.
                if (in_valid && in_ready_q) begin
                    shift_d    = word;
                    bitcnt_d   = '0;
                    div_d      = '0;
                    state_d    = SHIFT;
                    in_ready_d = 1'b0;
                    sframe_d   = 1'b1;
                    sdata_d    = word[bit_idx(6'd0)];
                end
            end
            SHIFT: begin
                sframe_d = 1'b1;
                sdata_d  = sdata_q;
                if (div_q == DIV_LAST) begin
                    div_d    = '0;
                    bitcnt_d = next_cnt;
                    if (bitcnt_q == 6'd63) begin
                        state_d    = IDLE;
                        sframe_d   = 1'b0;
                        sdata_d    = 1'b0;
                        done_d     = 1'b1;
                        in_ready_d = 1'b1;
                    end else begin
                        sdata_d = shift_q[bit_idx(next_cnt)];
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign in_ready = in_ready_q;
    assign sdata    = sdata_q;
    assign sframe   = sframe_q;
    assign done     = done_q;

endmodule

// File: tb/tb_parallel_to_serial.sv
// Bench for parallel_to_serial: instance A is LSB-first/div 1, instance B is
// MSB-first/div 4; expected serial bits are queued at transfer and popped per frame cycle.
module tb_parallel_to_serial;

    logic        clk;
    logic        reset;
    logic [63:0] a_word, b_word;
    logic        a_valid, b_valid;
    logic        a_in_ready, a_sdata, a_sframe, a_done;
    logic        b_in_ready, b_sdata, b_sframe, b_done;

    int total = 0;
    int bad   = 0;
    int a_done_cnt = 0;
    int b_done_cnt = 0;
    bit qa[$];
    bit qb[$];

    parallel_to_serial #(.BIT_DIV(1), .MSB_FIRST(1'b0)) dut_a (
        .clk(clk), .reset(reset),
        .D0(a_word[7:0]),   .D1(a_word[15:8]),  .D2(a_word[23:16]), .D3(a_word[31:24]),
        .D4(a_word[39:32]), .D5(a_word[47:40]), .D6(a_word[55:48]), .D7(a_word[63:56]),
        .in_valid(a_valid), .in_ready(a_in_ready),
        .sdata(a_sdata), .sframe(a_sframe), .done(a_done)
    );

    parallel_to_serial #(.BIT_DIV(4), .MSB_FIRST(1'b1)) dut_b (
        .clk(clk), .reset(reset),
        .D0(b_word[7:0]),   .D1(b_word[15:8]),  .D2(b_word[23:16]), .D3(b_word[31:24]),
        .D4(b_word[39:32]), .D5(b_word[47:40]), .D6(b_word[55:48]), .D7(b_word[63:56]),
        .in_valid(b_valid), .in_ready(b_in_ready),
        .sdata(b_sdata), .sframe(b_sframe), .done(b_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Scoreboard consumers: one expected bit per framed cycle.
    always @(negedge clk) begin
        if (a_sframe) begin
            total++;
            if (qa.size() == 0) begin
                bad++;
                $display("FAIL a_stream: sdata=%0b while no bit expected", a_sdata);
            end else begin
                bit e;
                e = qa.pop_front();
                if (a_sdata !== e) begin
                    bad++;
                    $display("FAIL a_stream: sdata=%0b expected=%0b", a_sdata, e);
                end
            end
        end
        if (b_sframe) begin
            total++;
            if (qb.size() == 0) begin
                bad++;
                $display("FAIL b_stream: sdata=%0b while no bit expected", b_sdata);
            end else begin
                bit e;
                e = qb.pop_front();
                if (b_sdata !== e) begin
                    bad++;
                    $display("FAIL b_stream: sdata=%0b expected=%0b", b_sdata, e);
                end
            end
        end
        if (a_done) a_done_cnt++;
        if (b_done) b_done_cnt++;
    end

    task automatic push_word(input bit sel, input logic [63:0] w);
        for (int i = 0; i < 64; i++) begin
            if (sel) begin
                for (int r = 0; r < 4; r++) qb.push_back(w[63 - i]);
            end else begin
                qa.push_back(w[i]);
            end
        end
        $display("push %s word=%016h", sel ? "B" : "A", w);
    endtask

    task automatic send(input bit sel, input logic [63:0] w);
        int n = 0;
        @(posedge clk); #1;
        while (!(sel ? b_in_ready : a_in_ready) && n < 500) begin
            @(posedge clk); #1;
            n++;
        end
        total++;
        if (n >= 500) begin
            bad++;
            $display("FAIL send_timeout: in_ready=0 required=1");
        end
        push_word(sel, w);
        if (sel) begin b_word = w; b_valid = 1'b1; end
        else     begin a_word = w; a_valid = 1'b1; end
        @(posedge clk); #1;
        if (sel) b_valid = 1'b0; else a_valid = 1'b0;
    endtask

    // Follows one frame until its done pulse; optionally perturbs A's inputs mid-frame.
    task automatic run_frame(input bit sel, input int exp_len, input bit poke, output int lead);
        int len = 0;
        bit seen = 0;
        lead = 0;
        for (int c = 0; c < 2000 && !seen; c++) begin
            logic sf, dn, rdy;
            @(negedge clk);
            sf  = sel ? b_sframe   : a_sframe;
            dn  = sel ? b_done     : a_done;
            rdy = sel ? b_in_ready : a_in_ready;
            if (!sf && !dn && len == 0) lead++;
            if (sf) len++;
            if (poke && len >= 10 && len < 16) begin
                a_word  = {$urandom, $urandom};
                a_valid = 1'b1;
                total++;
                if (a_in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL ignore_ready: in_ready=%0b required=0", a_in_ready);
                end
            end
            if (poke && len >= 16) a_valid = 1'b0;
            if (dn) begin
                seen = 1;
                total += 3;
                if (rdy !== 1'b1) begin
                    bad++;
                    $display("FAIL done_ready: in_ready=%0b required=1", rdy);
                end
                if (sf !== 1'b0) begin
                    bad++;
                    $display("FAIL done_sframe: sframe=%0b required=0", sf);
                end
                if (len != exp_len) begin
                    bad++;
                    $display("FAIL frame_len: got=%0d required=%0d", len, exp_len);
                end
                $display("frame %s len=%0d", sel ? "B" : "A", len);
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL frame_timeout: no done pulse within bound");
        end
    endtask

    task automatic test_reset();
        reset = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total += 5;
        if (a_in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got=%0b required=0", a_in_ready); end
        if (a_sdata    !== 1'b0) begin bad++; $display("FAIL reset_sdata: got=%0b required=0", a_sdata); end
        if (a_sframe   !== 1'b0) begin bad++; $display("FAIL reset_sframe: got=%0b required=0", a_sframe); end
        if (a_done     !== 1'b0) begin bad++; $display("FAIL reset_done: got=%0b required=0", a_done); end
        if (b_in_ready !== 1'b0) begin bad++; $display("FAIL reset_ready_b: got=%0b required=0", b_in_ready); end
        reset = 1'b1;
        @(posedge clk); #1;
        total += 3;
        if (a_in_ready !== 1'b1) begin bad++; $display("FAIL release_ready: got=%0b required=1", a_in_ready); end
        if (a_sframe   !== 1'b0) begin bad++; $display("FAIL release_sframe: got=%0b required=0", a_sframe); end
        if (b_in_ready !== 1'b1) begin bad++; $display("FAIL release_ready_b: got=%0b required=1", b_in_ready); end
        $display("test_reset finished");
    endtask

    task automatic test_basic();
        int lead;
        int d0 = a_done_cnt;
        send(1'b0, 64'h8000_0000_0000_0001);
        run_frame(1'b0, 64, 1'b0, lead);
        @(negedge clk);
        total += 3;
        if (a_done !== 1'b0) begin bad++; $display("FAIL done_width: done=%0b required=0", a_done); end
        if (a_done_cnt - d0 != 1) begin bad++; $display("FAIL done_count: got=%0d required=1", a_done_cnt - d0); end
        if (qa.size() != 0) begin bad++; $display("FAIL basic_leftover: got=%0d required=0", qa.size()); end
        $display("test_basic finished");
    endtask

    task automatic test_order_div();
        int lead;
        send(1'b1, 64'hA5A5_0000_0000_00FF);
        run_frame(1'b1, 256, 1'b0, lead);
        total++;
        if (qb.size() != 0) begin bad++; $display("FAIL order_leftover: got=%0d required=0", qb.size()); end
        $display("test_order_div finished");
    endtask

    task automatic test_back_to_back();
        int lead;
        int d0 = a_done_cnt;
        @(posedge clk); #1;
        push_word(1'b0, 64'hFFFF_FFFF_FFFF_FFFF);
        a_word = 64'hFFFF_FFFF_FFFF_FFFF;
        a_valid = 1'b1;
        @(posedge clk); #1;
        push_word(1'b0, 64'h0);
        a_word = 64'h0;
        run_frame(1'b0, 64, 1'b0, lead);
        fork
            begin
                @(posedge clk); #1;
                a_valid = 1'b0;
            end
        join_none
        run_frame(1'b0, 64, 1'b0, lead);
        @(negedge clk);
        total += 3;
        if (lead != 0) begin bad++; $display("FAIL b2b_gap: extra idle=%0d required=0", lead); end
        if (a_done_cnt - d0 != 2) begin bad++; $display("FAIL b2b_done: got=%0d required=2", a_done_cnt - d0); end
        if (qa.size() != 0) begin bad++; $display("FAIL b2b_leftover: got=%0d required=0", qa.size()); end
        $display("test_back_to_back finished");
    endtask

    task automatic test_ignore_shift();
        int lead;
        send(1'b0, 64'h0123_4567_89AB_CDEF);
        run_frame(1'b0, 64, 1'b1, lead);
        a_valid = 1'b0;
        repeat (4) begin
            @(negedge clk);
            total++;
            if (a_sframe !== 1'b0) begin bad++; $display("FAIL ignore_extra: sframe=%0b required=0", a_sframe); end
        end
        $display("test_ignore_shift finished");
    endtask

    task automatic test_reset_mid();
        int lead;
        int d0 = a_done_cnt;
        send(1'b0, 64'hDEAD_BEEF_F00D_CAFE);
        repeat (19) @(posedge clk);
        #3;
        reset = 1'b0;
        #1;
        qa.delete();
        total += 3;
        if (a_sframe !== 1'b0) begin bad++; $display("FAIL midrst_sframe: got=%0b required=0", a_sframe); end
        if (a_sdata  !== 1'b0) begin bad++; $display("FAIL midrst_sdata: got=%0b required=0", a_sdata); end
        if (a_done   !== 1'b0) begin bad++; $display("FAIL midrst_done: got=%0b required=0", a_done); end
        repeat (2) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        repeat (80) @(negedge clk);
        total++;
        if (a_done_cnt != d0) begin bad++; $display("FAIL midrst_nodone: got=%0d required=%0d", a_done_cnt, d0); end
        send(1'b0, 64'h5A5A_3C3C_0F0F_9669);
        run_frame(1'b0, 64, 1'b0, lead);
        total++;
        if (qa.size() != 0) begin bad++; $display("FAIL midrst_leftover: got=%0d required=0", qa.size()); end
        $display("test_reset_mid finished");
    endtask

    initial begin
        reset   = 1'b0;
        a_word  = '0;
        b_word  = '0;
        a_valid = 1'b0;
        b_valid = 1'b0;
        test_reset();
        test_basic();
        test_order_div();
        test_back_to_back();
        test_ignore_shift();
        test_reset_mid();
        repeat (3) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/parallel_to_serial.md
# parallel_to_serial

Transmit-side counterpart of the byte-lane deserializer. Accepts one 64-bit word as eight byte lanes (D0 = bits [7:0] … D7 = bits [63:56]) through a valid/ready handshake, then shifts it out one bit at a time on a framed serial line. The bit rate is programmable as a divide of the system clock. It sits between the parallel datapath and the serial link whose far end feeds the deserializer.

## Interface
Parameters:
- BIT_DIV, default 1: clock cycles per serial bit; legal range 1..256.
- MSB_FIRST, default 0: 0 = word bit 0 first, bit 63 last; 1 = bit 63 first, bit 0 last.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-low reset.
- D0..D7  input  8 each  byte lanes of the word to send; D0 = word[7:0], D7 = word[63:56].
- in_valid  input  1  the word on D0..D7 is valid.
- in_ready  output  1  block can accept a word this cycle.
- sdata  output  1  serial data bit.
- sframe  output  1  high for every cycle in which sdata carries a frame bit.
- done  output  1  one-cycle pulse after the last bit period of a frame.

## Operation
- Reset (reset = 0) takes effect immediately, independent of clk.
  - State goes to IDLE.
  - Shift register, bit counter (6 bits) and divider counter go to 0.
  - Outputs: in_ready = 0, sdata = 0, sframe = 0, done = 0.
- First rising clk after reset deassertion: in_ready rises to 1.
- State IDLE:
  - Outputs: in_ready = 1, sframe = 0, sdata = 0.
  - A transfer occurs when in_valid = 1 and in_ready = 1 at a rising edge. On that edge:
    - {D7..D0} is captured into the 64-bit shift register.
    - Bit counter and divider clear.
    - State goes to SHIFT.
- State SHIFT:
  - Outputs: in_ready = 0, sframe = 1.
  - sdata is word[bitcnt] for MSB_FIRST = 0, and word[63 - bitcnt] for MSB_FIRST = 1.
  - The divider counts 0..BIT_DIV-1. On wrap it resets to 0 and bitcnt increments.
  - Bit counter arithmetic: 6-bit, no saturation needed. The terminal condition is bitcnt = 63 with divider = BIT_DIV-1.
  - At the terminal condition: state goes to IDLE and done = 1 for exactly the following cycle.
- D0..D7 and in_valid are ignored outside the transfer edge. Changing D during SHIFT does not affect the frame in flight.
- Reset mid-frame: the frame is abandoned and done is not pulsed. sframe drops asynchronously.
- done and in_ready may be high in the same cycle. A new transfer may be accepted in that cycle.

## Timing
- Frame start latency: transfer at edge N gives sframe = 1 and the first bit on sdata from edge N through edge N + 64·BIT_DIV.
- Each bit is held for exactly BIT_DIV cycles. Total frame length is 64·BIT_DIV cycles, with no gaps between bits.
- After the last bit period there is one cycle with sframe = 0, in_ready = 1 and done = 1.
- Back-to-back frames with in_valid held high are separated by exactly one idle cycle. Throughput is 64 bits per 64·BIT_DIV + 1 cycles.
- All outputs are registered. There is no combinational path from D or in_valid to any output.

## Test plan
- Reset value check: hold reset = 0 and toggle clk.
  - Required: in_ready = sdata = sframe = done = 0.
  - Release reset: in_ready = 1 after one edge and sframe stays 0.
- Basic frame, BIT_DIV = 1, MSB_FIRST = 0: send D0..D7 = 0x01, 0x00, 0x00, 0x00, 0x00, 0x00, 0x00, 0x80.
  - Required: sframe high for 64 cycles; sdata = 1 on cycle 0, 0 on cycles 1–62, 1 on cycle 63.
  - Then done pulses once and in_ready = 1 in the same cycle.
- Bit order and divider, MSB_FIRST = 1, BIT_DIV = 4: send word 0xA5A5_0000_0000_00FF.
  - Required: the first 8 bits are 1,0,1,0,0,1,0,1, each held 4 cycles.
  - The last 8 bits are 1; the frame lasts 256 cycles.
- Back-to-back: hold in_valid = 1 with words 0xFFFF_FFFF_FFFF_FFFF and then 0x0.
  - Required: exactly one cycle with sframe = 0 between the frames.
  - The second frame is all zeros; two done pulses are observed.
- Ignore during SHIFT: change D0..D7 and pulse in_valid mid-frame.
  - Required: in_ready stays 0, the serial stream is unchanged, and no extra frame is sent.
- Reset mid-frame: assert reset at bit 20 of a frame, asynchronously between clock edges.
  - Required: sframe and sdata drop to 0 immediately and done never pulses.
  - After release, a new word transfers and serializes correctly.
